// File: rtl/membus.sv
// Bus responder for the 6502 core: RAM front end with wait states,
// plus an 8-byte I/O window holding an interval timer and interrupts.
module membus #(
  parameter logic [15:0] IO_BASE  = 16'hC000,
  parameter logic [7:0]  ID_VALUE = 8'h65
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        we,
  input  logic [7:0]  cpu_out,
  output logic [7:0]  cpu_in,
  output logic        hold,
  output logic        intr,
  output logic [15:0] mem_address,
  input  logic [7:0]  mem_in,
  output logic [7:0]  mem_out,
  output logic        mem_we
);

  logic [15:0] last_addr_q, last_addr_d;
  logic        valid_q, valid_d;
  logic [7:0]  reload_lo_q, reload_lo_d;
  logic [7:0]  reload_hi_q, reload_hi_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        exp_q, exp_d;
  logic [7:0]  snap_hi_q, snap_hi_d;
  logic        swirq_q, swirq_d;
  logic [15:0] counter_q, counter_d;
  logic        intr_q, intr_d;

  logic        match;
  logic        io_sel;
  logic        last_io;
  logic        io_wr;
  logic [7:0]  wr_sel;
  logic        expire;
  logic        en_rise;
  logic [15:0] reload;
  logic [7:0]  io_rdata;

  assign match   = valid_q & (address == last_addr_q);
  assign io_sel  = address[15:3] == IO_BASE[15:3];
  assign last_io = last_addr_q[15:3] == IO_BASE[15:3];
  assign io_wr   = we & match & io_sel;
  assign wr_sel  = io_wr ? (8'b1 << address[2:0]) : 8'b0;
  assign reload  = {reload_hi_q, reload_lo_q};

  assign expire  = ctrl_q[0] & (counter_q == 16'h0000);
  assign en_rise = wr_sel[2] & ~ctrl_q[0] & cpu_out[0];

  assign hold        = reset | match;
  assign mem_address = address;
  assign mem_out     = cpu_out;
  assign mem_we      = we & match & ~io_sel & ~reset;
  assign intr        = intr_q;

  always_comb begin
    io_rdata = 8'h00;
    case (last_addr_q[2:0])
      3'd0: io_rdata = reload_lo_q;
      3'd1: io_rdata = reload_hi_q;
      3'd2: io_rdata = {5'b0, ctrl_q};
      3'd3: io_rdata = {7'b0, exp_q};
      3'd4: io_rdata = counter_q[7:0];
      3'd5: io_rdata = snap_hi_q;
      3'd6: io_rdata = {7'b0, swirq_q};
      3'd7: io_rdata = ID_VALUE;
    endcase
  end

  always_comb begin
    cpu_in = mem_in;
    if (reset)
      cpu_in = 8'h00;
    else if (last_io)
      cpu_in = io_rdata;
  end

  // A commit drops valid so the next access re-reads post-write data.
  always_comb begin
    last_addr_d = address;
    valid_d     = ~(we & match);
    reload_lo_d = reload_lo_q;
    reload_hi_d = reload_hi_q;
    swirq_d     = swirq_q;
    snap_hi_d   = snap_hi_q;
    if (wr_sel[0]) reload_lo_d = cpu_out;
    if (wr_sel[1]) reload_hi_d = cpu_out;
    if (wr_sel[6]) swirq_d = cpu_out[0];
    if (match & ~we & io_sel & (address[2:0] == 3'd4))
      snap_hi_d = counter_q[15:8];
  end

  // Timer steps on the old EN; a CTRL write overrides a one-shot stop.
  always_comb begin
    counter_d = counter_q;
    ctrl_d    = ctrl_q;
    exp_d     = exp_q;
    if (en_rise)
      counter_d = reload;
    else if (ctrl_q[0])
      counter_d = expire ? reload : counter_q - 16'd1;
    if (expire & ctrl_q[2])
      ctrl_d[0] = 1'b0;
    if (wr_sel[2])
      ctrl_d = cpu_out[2:0];
    if (wr_sel[3] & cpu_out[0])
      exp_d = 1'b0;
    if (expire)
      exp_d = 1'b1;
  end

  assign intr_d = (exp_d & ctrl_d[1]) | swirq_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_addr_q <= 16'h0000;
      valid_q     <= 1'b0;
      reload_lo_q <= 8'h00;
      reload_hi_q <= 8'h00;
      ctrl_q      <= 3'b000;
      exp_q       <= 1'b0;
      snap_hi_q   <= 8'h00;
      swirq_q     <= 1'b0;
      counter_q   <= 16'h0000;
      intr_q      <= 1'b0;
    end else begin
      last_addr_q <= last_addr_d;
      valid_q     <= valid_d;
      reload_lo_q <= reload_lo_d;
      reload_hi_q <= reload_hi_d;
      ctrl_q      <= ctrl_d;
      exp_q       <= exp_d;
      snap_hi_q   <= snap_hi_d;
      swirq_q     <= swirq_d;
      counter_q   <= counter_d;
      intr_q      <= intr_d;
    end
  end

endmodule

// File: tb/tb_membus.sv
// Directed bench for membus: RAM waits/writes, timer, interrupts,
// I/O registers and reset behaviour, against a behavioural RAM.
module tb_membus;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        we;
  logic [7:0]  cpu_out;
  logic [7:0]  cpu_in;
  logic        hold;
  logic        intr;
  logic [15:0] mem_address;
  logic [7:0]  mem_in;
  logic [7:0]  mem_out;
  logic        mem_we;

  logic        pre_we;
  logic [15:0] pre_a;
  logic [7:0]  pre_d;
  logic [7:0]  ram [0:65535];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_we     = 0;
  int n;
  int m;
  logic [7:0] rd;

  membus dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .we          (we),
    .cpu_out     (cpu_out),
    .cpu_in      (cpu_in),
    .hold        (hold),
    .intr        (intr),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .mem_out     (mem_out),
    .mem_we      (mem_we)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pre_we)
      ram[pre_a] <= pre_d;
    else if (mem_we === 1'b1)
      ram[mem_address] <= mem_out;
    mem_in <= ram[mem_address];
    if (mem_we === 1'b1)
      n_we <= n_we + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    bit done;
    done = 1'b0;
    address = a;
    we = 1'b1;
    cpu_out = d;
    for (int i = 0; i < 4 && !done; i++) begin
      #1;
      if (hold) done = 1'b1;
      tick();
    end
    we = 1'b0;
    chk("wr_done", {15'b0, done}, 16'd1);
  endtask

  task automatic io_read(input logic [15:0] a, output logic [7:0] d);
    bit got;
    got = 1'b0;
    d = 8'hxx;
    address = a;
    we = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      #1;
      if (hold) begin
        d = cpu_in;
        got = 1'b1;
      end
      tick();
    end
    chk("rd_done", {15'b0, got}, 16'd1);
  endtask

  initial begin
    reset = 1'b1;
    address = 16'h0300;
    we = 1'b1;
    cpu_out = 8'hEE;
    pre_we = 1'b1;
    pre_a = 16'h1234; pre_d = 8'hA9;
    tick();
    pre_a = 16'h0200; pre_d = 8'h11;
    tick();
    pre_a = 16'h0300; pre_d = 8'h33;
    tick();
    pre_we = 1'b0;
    #1;
    chk("rst_hold", {15'b0, hold}, 16'd1);
    chk("rst_intr", {15'b0, intr}, 16'd0);
    chk("rst_mem_we", {15'b0, mem_we}, 16'd0);
    chk("rst_cpu_in", {8'b0, cpu_in}, 16'h0000);

    reset = 1'b0;
    we = 1'b0;
    address = 16'h1234;
    #1;
    chk("post_rst_hold", {15'b0, hold}, 16'd0);
    tick();
    #1;
    chk("rd_hold", {15'b0, hold}, 16'd1);
    chk("rd_data", {8'b0, cpu_in}, 16'h00A9);
    tick();
    #1;
    chk("rd_nowait", {15'b0, hold}, 16'd1);
    chk("rd_data2", {8'b0, cpu_in}, 16'h00A9);

    address = 16'h0200;
    tick();
    we = 1'b1;
    cpu_out = 8'h5A;
    #1;
    chk("wr_mem_we", {15'b0, mem_we}, 16'd1);
    chk("wr_addr", mem_address, 16'h0200);
    chk("wr_data", {8'b0, mem_out}, 16'h005A);
    tick();
    we = 1'b0;
    #1;
    chk("wr_pulse_end", {15'b0, mem_we}, 16'd0);
    chk("wr_reread_wait", {15'b0, hold}, 16'd0);
    tick();
    #1;
    chk("wr_reread_hold", {15'b0, hold}, 16'd1);
    chk("wr_reread_data", {8'b0, cpu_in}, 16'h005A);
    tick();

    io_write(16'hC000, 8'h03);
    io_write(16'hC001, 8'h00);
    io_write(16'hC002, 8'h03);
    n = cyc - 1;
    #1;
    chk("intr_n1", {15'b0, intr}, 16'd0);
    while (cyc < n + 4) tick();
    #1;
    chk("intr_n4", {15'b0, intr}, 16'd0);
    tick();
    #1;
    chk("intr_rise_n5", {15'b0, intr}, 16'd1);
    io_write(16'hC003, 8'h01);
    address = 16'h0000;
    #1;
    chk("status_clear", {15'b0, intr}, 16'd0);
    chk("status_clear_cyc", cyc[15:0], n[15:0] + 16'd7);
    tick();
    #1;
    chk("intr_n8", {15'b0, intr}, 16'd0);
    tick();
    #1;
    chk("period4_n9", {15'b0, intr}, 16'd1);
    while (cyc < n + 11) tick();
    io_write(16'hC003, 8'h01);
    #1;
    chk("collision_intr", {15'b0, intr}, 16'd1);
    io_read(16'hC003, rd);
    chk("collision_exp", {8'b0, rd}, 16'h0001);

    io_write(16'hC002, 8'h00);
    io_write(16'hC002, 8'h07);
    m = cyc - 1;
    while (cyc < m + 6) tick();
    io_read(16'hC002, rd);
    chk("oneshot_ctrl", {8'b0, rd}, 16'h0006);
    io_write(16'hC002, 8'h00);
    io_write(16'hC003, 8'h01);
    #1;
    chk("intr_cleared", {15'b0, intr}, 16'd0);

    io_read(16'hC007, rd);
    chk("id_reg", {8'b0, rd}, 16'h0065);
    io_write(16'hC006, 8'h01);
    #1;
    chk("swirq_on", {15'b0, intr}, 16'd1);
    io_write(16'hC006, 8'h00);
    #1;
    chk("swirq_off", {15'b0, intr}, 16'd0);

    io_write(16'hC000, 8'h82);
    io_write(16'hC001, 8'h12);
    io_write(16'hC002, 8'h01);
    io_write(16'hC002, 8'h00);
    io_read(16'hC004, rd);
    chk("cnt_lo", {8'b0, rd}, 16'h0080);
    io_read(16'hC005, rd);
    chk("snap_hi", {8'b0, rd}, 16'h0012);
    io_read(16'hC000, rd);
    chk("reload_lo", {8'b0, rd}, 16'h0082);

    address = 16'h0300;
    we = 1'b0;
    tick();
    reset = 1'b1;
    we = 1'b1;
    cpu_out = 8'hEE;
    #1;
    chk("rst_wr_mem_we", {15'b0, mem_we}, 16'd0);
    chk("rst_wr_hold", {15'b0, hold}, 16'd1);
    chk("rst_wr_cpu_in", {8'b0, cpu_in}, 16'h0000);
    tick();
    reset = 1'b0;
    we = 1'b0;
    io_read(16'h0300, rd);
    chk("rst_no_commit", {8'b0, rd}, 16'h0033);
    chk("we_pulses", n_we[15:0], 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/membus.md
# membus

Bus responder for the 6502 `core`: the memory/I-O end of its `address`/`in`/`out`/`we`/`hold`/`intr` interface.
- Fronts a synchronous single-port RAM with one-cycle read latency and inserts wait states through `hold`.
- Decodes an 8-byte I/O window holding a 16-bit interval timer and the interrupt source that drives the core's `intr`.

## Interface
- `IO_BASE`, default 16'hC000: base of the 8-byte I/O window; `IO_BASE[2:0]` must be 0.
- `ID_VALUE`, default 8'h65: constant returned by I/O register 7.

Ports:
- `clock` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in 16: bus address from the core.
- `we` in 1: write strobe from the core.
- `cpu_out` in 8: write data from the core (the core's `out`).
- `cpu_in` out 8: read data to the core (the core's `in`).
- `hold` out 1: core clock-enable. 1 = the core advances this cycle.
- `intr` out 1: level interrupt. The core edge-detects it.
- `mem_address` out 16: RAM address, equal to `address` combinationally.
- `mem_in` in 8: RAM read data for the address presented in the previous cycle.
- `mem_out` out 8: RAM write data, equal to `cpu_out`.
- `mem_we` out 1: RAM write enable.

## Operation
Bus tracking state:
- `last_addr`: takes `address` every cycle.
- `valid`: set to 1 every cycle except as noted below.
- `match = valid & (address == last_addr)`.

Bus outputs:
- `hold = reset | match`. `hold` is 1 during reset so the core's own synchronous reset is processed.
- Master rule: `address`, `we` and `cpu_out` must stay stable while `hold` = 0.

Reads:
- A new address costs exactly one wait cycle. When `match` = 1, the data is valid.
- `cpu_in` source:
  - `last_addr` inside the window: I/O read mux.
  - Otherwise: `mem_in`.
  - During reset: 0.

Writes:
- A write commits on a cycle with `we & match`.
- RAM address: `mem_we = we & match & ~io_sel`.
- I/O address: the register is updated at the clock edge.
- The commit edge clears `valid` to 0, so the next access re-reads and returns post-write data.

I/O window (offset = `address[2:0]`; `io_sel` when `address[15:3] == IO_BASE[15:3]`):
- 0 RELOAD_LO (R/W), 1 RELOAD_HI (R/W).
- 2 CTRL (R/W): bit0 EN, bit1 IRQEN, bit2 ONESHOT; other bits read 0.
- 3 STATUS: bit0 EXP. Write 1 clears; write 0 has no effect.
- 4 CNT_LO (R): reads live `counter[7:0]`. Any read cycle (`match & ~we`) copies `counter[15:8]` into SNAP_HI.
- 5 SNAP_HI (R); writes ignored.
- 6 SWIRQ (R/W): bit0 is the software interrupt.
- 7 ID (R): reads `ID_VALUE`; writes ignored.

Timer (`counter`, 16 bits; runs on every clock, independent of `hold`):
- A CTRL write that takes EN from 0 to 1 loads `counter <= {RELOAD_HI, RELOAD_LO}`.
- While EN = 1 and `counter != 0`: `counter` decrements.
- While EN = 1 and `counter == 0` (expiry):
  - EXP <= 1 and `counter` reloads.
  - If ONESHOT = 1, EN <= 0.
- Period = reload + 1 cycles. Reload 0 expires every cycle.
- RELOAD writes do not disturb a running count.
- `intr = (EXP & IRQEN) | SWIRQ[0]`, registered.

## Timing
- Reset values: `cpu_in` 0, `hold` 1, `intr` 0, `mem_we` 0; all registers, `counter`, SNAP_HI and `valid` are 0.
- First cycle after reset: `hold` = 0 (`valid` = 0).
- Read latency:
  - Address change at cycle n: `hold` = 0 at n, `hold` = 1 with valid `cpu_in` at n+1.
  - Repeated same address: zero wait.
- Write: if the address is already matched, the commit happens in the same cycle, then `valid` = 0 for one cycle.
- `intr`: updates one cycle after EXP/IRQEN/SWIRQ change.
- Simultaneous events:
  - STATUS clear in the same cycle as an expiry: EXP stays 1.
  - CTRL write of EN = 0 in the same cycle as an expiry: EXP is set, `counter` reloads, EN ends 0.
  - ONESHOT expiry in the same cycle as a CTRL write: the written value wins.
- Reset mid-write: `mem_we` is forced 0, with no partial commit.

## Test plan
- Reset: hold `reset` high for 3 cycles → `hold` = 1, `intr` = 0, `mem_we` = 0, `cpu_in` = 0. First cycle after release: `hold` = 0.
- RAM read: preload 0x1234 = 0xA9, present 0x1234 → `hold` 0 then 1 with `cpu_in` = 0xA9. Holding the address keeps `hold` = 1 with no further waits.
- RAM write: at matched 0x0200, `we` = 1, `cpu_out` = 0x5A → exactly one `mem_we` pulse (addr 0x0200, data 0x5A). The following read of 0x0200 waits one cycle and returns 0x5A.
- Timer: write reload 0x0003, then CTRL = 0x03 committed at cycle n:
  - EXP and `intr` rise at n+5.
  - Expiries repeat every 4 cycles.
  - STATUS write 0x01 drops `intr` one cycle after commit (if no expiry that cycle).
  - With ONESHOT: CTRL reads 0x06 after the first expiry.
- Collision: STATUS clear commit coincides with expiry → EXP stays 1 and `intr` stays high.
- I/O misc:
  - Read offset 7 → 0x65.
  - Write SWIRQ = 1 → `intr` high next cycle; write 0 → low.
  - With `counter` = 0x1280, read CNT_LO → 0x80, then SNAP_HI → 0x12.
